pio_arbiter: RTL and testbench
==============================

PIO_ARBITER -- requirements
Module: pio_arbiter

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 64: idle cycles a held lock survives without an owner request.
REQ-002 Parameter DW, default 8: PIO port width; readdata bits above DW are ignored.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rq_valid[1:0]  input  2  per-requester command valid.
REQ-006 rq_ready[1:0]  output  2  command accepted when rq_valid[i] and rq_ready[i] are both high; one-hot or zero.
REQ-007 rq_write[1:0], rq_lock[1:0]  input  2 each  per requester: 1 means write; 1 means keep the grant after this command.
REQ-008 rq_addr0/rq_addr1  input  2 each  PIO register address (0 = data, 1 = direction).
REQ-009 rq_wdata0/rq_wdata1  input  32 each  write data.
REQ-010 rs_valid[1:0]  output  2  one-cycle response pulse to the owning requester.
REQ-011 rs_rdata  output  32  read data, valid while any rs_valid bit is high.
REQ-012 address  output  2; chipselect  output  1; write_n  output  1; writedata  output  32: PIO slave port.
REQ-013 readdata  input  32  PIO readdata, registered in the slave with 1-cycle latency.
REQ-014 busy  output  1  high in any state other than IDLE or while a lock is held.
REQ-015 lock_timeout  output  1  one-cycle pulse when a lock is force-released.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; each transaction takes exactly 3 cycles: accept, ISSUE, RESP.
REQ-017 In IDLE the arbiter selects one requester and asserts its rq_ready combinationally; on acceptance it registers addr, write, wdata, lock and owner, then moves to ISSUE.
REQ-018 IDLE selection with no lock held and both requesters valid: round-robin, favouring the requester not granted last.
REQ-019 IDLE selection with a lock held: only the lock owner is eligible; the other rq_ready stays 0.
REQ-020 ISSUE drives the bus for exactly one cycle: chipselect=1, address=registered addr, write_n=~registered write, writedata=registered wdata.
REQ-021 Outside ISSUE the bus is idle: chipselect=0, write_n=1, address=0, writedata=0.
REQ-022 RESP pulses rs_valid[owner] for one cycle; for reads rs_rdata = readdata zero-extended above DW, for writes rs_rdata = 0; the FSM then returns to IDLE.
REQ-023 rs_rdata = 0 whenever rs_valid = 0.
REQ-024 A lock is set at acceptance with rq_lock=1 and cleared at acceptance of an owner command with rq_lock=0.
REQ-025 A lock counter counts IDLE cycles while a lock is held and the owner is not valid; it resets on owner acceptance.
REQ-026 When the lock counter reaches LOCK_TIMEOUT, the lock clears, lock_timeout pulses for one cycle, and arbitration resumes the next cycle.
REQ-027 rq_valid changes during ISSUE or RESP are ignored; rq_ready = 0 outside IDLE.
REQ-028 A timeout and an owner request in the same cycle: the owner request wins and the lock is not dropped.
REQ-029 A locked read-modify-write (locked read, then unlocked write) occupies 6 cycles with no interleaved foreign access.

Reset
REQ-030 Reset values: state=IDLE, chipselect=0, write_n=1, address=0, writedata=0, rq_ready=0, rs_valid=0, rs_rdata=0, busy=0, lock_timeout=0, lock cleared, counter=0, round-robin pointer favouring requester 0.
REQ-031 Reset mid-transaction aborts it: no response pulse is produced and the bus is idle from the cycle after reset is sampled.

Structure
REQ-032 Shared package pio_arb_pkg holds the state enum, ADDR_DATA=0, ADDR_DIR=1, and the requester-count constant 2.
REQ-033 Round-robin selection with lock masking lives in sub-module pio_arb_rr; the FSM, bus drive and lock timer live in pio_arbiter.

Verification
REQ-034 Req0 writes addr 1, data 0xFF -> one ISSUE cycle with chipselect=1, write_n=0, address=1, writedata=0xFF; rs_valid[0] two cycles after acceptance; rs_rdata=0.
REQ-035 Both requesters valid from reset, reading addr 0 with PIO input 0x5A -> grants alternate 0,1,0,1; each rs_rdata=0x5A; transaction starts are 3 cycles apart.
REQ-036 Req1 locked read of addr 0, then unlocked write 0x0F, with req0 valid throughout -> req0 gets no grant until the unlocked write is accepted; req0 is granted next.
REQ-037 LOCK_TIMEOUT=4: req0 locks, then goes idle while req1 is valid -> lock_timeout pulses after 4 IDLE cycles; req1 is granted on the next cycle.
REQ-038 Reset asserted during ISSUE of a read -> no rs_valid; chipselect=0 from the next cycle; all outputs at REQ-030 values.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the two-requester PIO arbiter.
package pio_arb_pkg;
  localparam int NUM_RQ = 2;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } pio_cmd_t;

  function automatic logic [NUM_RQ-1:0] rq_onehot(input logic idx);
    rq_onehot = idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/pio_arb_rr.sv
// Round-robin pick between the two requesters; a held lock masks everyone but its owner.
module pio_arb_rr
  import pio_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_RQ-1:0] valid,
  input  logic              lock,
  input  logic              owner,
  input  logic              accept,
  output logic [NUM_RQ-1:0] grant,
  output logic              sel
);
  logic              prio;
  logic [NUM_RQ-1:0] elig;

  always_comb begin
    elig  = lock ? (valid & rq_onehot(owner)) : valid;
    sel   = (elig[0] && elig[1]) ? prio : elig[1];
    grant = (elig != '0) ? rq_onehot(sel) : '0;
  end

  // prio names the requester to favour on the next tie: the one not granted last
  always_ff @(posedge clk) begin
    if (reset)       prio <= 1'b0;
    else if (accept) prio <= ~sel;
  end
endmodule

// File: rtl/pio_arbiter.sv
// Two-requester arbiter in front of a PIO slave: accept / ISSUE / RESP, with
// optional bus locking that is force-released after LOCK_TIMEOUT idle cycles.
module pio_arbiter
  import pio_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 64,
  parameter int DW           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_RQ-1:0] rq_valid,
  output logic [NUM_RQ-1:0] rq_ready,
  input  logic [NUM_RQ-1:0] rq_write,
  input  logic [NUM_RQ-1:0] rq_lock,
  input  logic [1:0]        rq_addr0,
  input  logic [1:0]        rq_addr1,
  input  logic [31:0]       rq_wdata0,
  input  logic [31:0]       rq_wdata1,
  output logic [NUM_RQ-1:0] rs_valid,
  output logic [31:0]       rs_rdata,
  output logic [1:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              lock_timeout
);
  localparam int          CW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] RD_MASK  = (DW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << DW) - 32'd1);

  arb_state_e        state, state_nx;
  pio_cmd_t          cmd_q, cmd_sel;
  logic              owner_q, lock_q;
  logic [CW-1:0]     cnt;
  logic [NUM_RQ-1:0] grant;
  logic              sel, accept, owner_valid, tmo_hit;

  pio_arb_rr u_rr (
    .clk    (clk),
    .reset  (reset),
    .valid  (rq_valid),
    .lock   (lock_q),
    .owner  (owner_q),
    .accept (accept),
    .grant  (grant),
    .sel    (sel)
  );

  always_comb begin
    rq_ready    = (state == IDLE && !reset) ? grant : '0;
    accept      = |(rq_valid & rq_ready);
    owner_valid = rq_valid[owner_q];
    // owner request beats a timeout landing in the same cycle
    tmo_hit     = (state == IDLE) && lock_q && !owner_valid && (cnt == TMO_LAST);
    cmd_sel     = sel ? '{write: rq_write[1], addr: rq_addr1, wdata: rq_wdata1}
                      : '{write: rq_write[0], addr: rq_addr0, wdata: rq_wdata0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cmd_q        <= '0;
      owner_q      <= 1'b0;
      lock_q       <= 1'b0;
      cnt          <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      lock_timeout <= tmo_hit;
      if (accept) begin
        cmd_q   <= cmd_sel;
        owner_q <= sel;
        lock_q  <= rq_lock[sel];
        cnt     <= '0;
      end else if (tmo_hit) begin
        lock_q <= 1'b0;
        cnt    <= '0;
      end else if (state == IDLE && lock_q && !owner_valid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    rs_valid   = '0;
    rs_rdata   = '0;
    busy       = (state != IDLE) || lock_q;
    case (state)
      ISSUE: begin
        chipselect = 1'b1;
        write_n    = ~cmd_q.write;
        address    = cmd_q.addr;
        writedata  = cmd_q.wdata;
      end
      RESP: begin
        rs_valid = rq_onehot(owner_q);
        rs_rdata = cmd_q.write ? 32'd0 : (readdata & RD_MASK);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pio_arbiter.sv
// Directed checks of the PIO arbiter: bus timing, round-robin, locking, timeout, reset abort.
module tb_pio_arbiter;
  import pio_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rq_valid = '0, rq_ready, rq_write = '0, rq_lock = '0;
  logic [1:0]  rq_addr0 = '0, rq_addr1 = '0;
  logic [31:0] rq_wdata0 = '0, rq_wdata1 = '0;
  logic [1:0]  rs_valid;
  logic [31:0] rs_rdata;
  logic [1:0]  address;
  logic        chipselect, write_n, busy, lock_timeout;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic [7:0]  pio_in = '0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          t0;
  logic [1:0]  exp;

  pio_arbiter #(.LOCK_TIMEOUT(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_write(rq_write), .rq_lock(rq_lock), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1), .rs_valid(rs_valid), .rs_rdata(rs_rdata),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .busy(busy), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  // PIO slave: registered readdata with junk above the 8-bit port
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    readdata <= {24'hC3C3C3, pio_in};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #2;
  endtask

  task automatic rst();
    reset = 1'b1; rq_valid = '0; rq_lock = '0; rq_write = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_cs"}, chipselect, 0);
    chk({tag, "_wn"}, write_n, 1);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_wd"}, writedata, 0);
    chk({tag, "_rsv"}, rs_valid, 0);
    chk({tag, "_rd"}, rs_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo"}, lock_timeout, 0);
    chk({tag, "_rdy"}, rq_ready, 0);
  endtask

  initial begin
    // reset values, sampled while reset is still asserted
    @(posedge clk); @(posedge clk); #2;
    idle_outs("rst");
    rst();

    // single write from req0
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr0 = ADDR_DIR; rq_wdata0 = 32'hFF; #1;
    chk("wr_rdy", rq_ready, 2'b01);
    nxt(); rq_valid = '0; #1;
    chk("wr_cs", chipselect, 1); chk("wr_wn", write_n, 0);
    chk("wr_addr", address, 1); chk("wr_wd", writedata, 32'hFF);
    chk("wr_rdy_issue", rq_ready, 0); chk("wr_busy", busy, 1);
    nxt();
    chk("wr_rsv", rs_valid, 2'b01); chk("wr_rd", rs_rdata, 0); chk("wr_cs_resp", chipselect, 0);
    nxt();
    chk("wr_rsv_done", rs_valid, 0); chk("wr_busy_done", busy, 0);

    // both reading from reset: alternating grants, upper readdata bits dropped
    rst();
    pio_in = 8'h5A; rq_write = '0; rq_addr0 = ADDR_DATA; rq_addr1 = ADDR_DATA; rq_valid = 2'b11;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_rdy", rq_ready, exp);
      if (k > 0) chk("rr_spacing", cyc - t0, 3);
      t0 = cyc;
      nxt();
      chk("rr_cs", chipselect, 1); chk("rr_wn", write_n, 1);
      nxt();
      chk("rr_rsv", rs_valid, exp); chk("rr_rd", rs_rdata, 32'h5A);
      nxt();
    end
    rq_valid = '0;

    // locked read-modify-write by req1 with req0 waiting throughout
    rst();
    pio_in = 8'h33;
    rq_valid = 2'b10; rq_lock = 2'b10; rq_write = 2'b00; rq_addr1 = ADDR_DATA; #1;
    chk("rmw_rdy_rd", rq_ready, 2'b10);
    nxt();
    rq_valid = 2'b11; rq_write = 2'b10; rq_lock = 2'b00; rq_wdata1 = 32'h0F; #1;
    chk("rmw_rdy_issue", rq_ready, 0);
    nxt();
    chk("rmw_rsv_rd", rs_valid, 2'b10); chk("rmw_rd", rs_rdata, 32'h33);
    nxt();
    chk("rmw_rdy_wr", rq_ready, 2'b10); chk("rmw_busy_lock", busy, 1);
    nxt();
    rq_valid = 2'b01; #1;
    chk("rmw_cs_wr", chipselect, 1); chk("rmw_wn_wr", write_n, 0); chk("rmw_wd", writedata, 32'h0F);
    nxt();
    chk("rmw_rsv_wr", rs_valid, 2'b10); chk("rmw_rd_wr", rs_rdata, 0);
    nxt();
    chk("rmw_rdy_req0", rq_ready, 2'b01);
    rq_valid = '0; nxt(); nxt(); nxt();

    // lock timeout: req0 locks then goes quiet while req1 waits
    rst();
    rq_valid = 2'b01; rq_lock = 2'b01; rq_write = '0; #1;
    chk("tmo_rdy_lock", rq_ready, 2'b01);
    nxt(); rq_valid = 2'b10; rq_lock = '0;
    nxt();
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("tmo_rdy_hold", rq_ready, 0); chk("tmo_pulse_early", lock_timeout, 0); chk("tmo_busy", busy, 1);
    end
    nxt();
    chk("tmo_pulse", lock_timeout, 1); chk("tmo_rdy_req1", rq_ready, 2'b10);
    nxt();
    chk("tmo_pulse_end", lock_timeout, 0); chk("tmo_cs", chipselect, 1);
    rq_valid = '0; nxt(); nxt();

    // owner returns on the cycle the timeout would fire: owner wins, lock kept
    rst();
    rq_valid = 2'b01; rq_lock = 2'b01; #1;
    nxt(); rq_valid = 2'b10;
    nxt();
    for (int k = 0; k < 3; k++) nxt();
    nxt();
    rq_valid = 2'b11; #1;
    chk("own_rdy", rq_ready, 2'b01); chk("own_tmo", lock_timeout, 0);
    nxt();
    chk("own_tmo_after", lock_timeout, 0); chk("own_cs", chipselect, 1);
    rq_valid = 2'b10; rq_lock = '0;
    nxt(); nxt();
    chk("own_lock_kept", rq_ready, 0); chk("own_busy", busy, 1);

    // reset during ISSUE of a read aborts it
    rst();
    rq_valid = 2'b01; rq_write = '0; #1;
    nxt(); rq_valid = '0; #1;
    chk("ab_cs_issue", chipselect, 1);
    reset = 1'b1;
    nxt();
    idle_outs("ab");
    reset = 1'b0;
    nxt();
    chk("ab_rsv_after", rs_valid, 0); chk("ab_cs_after", chipselect, 0); chk("ab_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
